// File: rtl/sq_seq_pkg.sv
// Shared types and sizes for the 3x3 window squaring sequencer.
package sq_seq_pkg;
    localparam int NUM_TAPS = 9;
    localparam int TAP_W    = 8;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/multiplier8bit8.sv
// Pipelined 8x8 multiplier returning the low byte of the product after LAT register stages.
module multiplier8bit8 #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] op1,
    input  logic [7:0] op2,
    output logic [7:0] res
);
    logic [15:0] prod;
    logic [7:0]  pipe [LAT];

    assign prod = {8'd0, op1} * {8'd0, op2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= prod[7:0];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign res = pipe[LAT-1];
endmodule

// File: rtl/sq_window_sequencer.sv
// Squares the nine taps of a 3x3 window through one shared multiplier8bit8.
// Optional window counter output enabled by defining SQ_SEQ_WINCNT_EN.
//
// state | meaning
// IDLE  | waiting for a window, in_ready high
// ISSUE | one tap per cycle into the multiplier
// DRAIN | collecting the remaining in-flight results
// DONE  | output window held until downstream accepts it
module sq_window_sequencer
    import sq_seq_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [71:0] c_in,
    input  logic [71:0] p_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] c_out,
    output logic [71:0] p_out,
    output logic        busy
`ifdef SQ_SEQ_WINCNT_EN
    ,
    output logic [15:0] win_count
`endif
);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] k;
    logic [71:0]      op_buf;
    tag_t             tags [MUL_LAT];
    tag_t             tag_in, tag_out;
    logic [7:0]       op_tap, mul_res;
    logic             accept, last_res, out_hs, last_issue;

    assign accept     = (state == IDLE) && in_valid;
    assign out_hs     = (state == DONE) && out_ready;
    assign last_issue = (k == IDX_W'(NUM_TAPS - 1));
    assign tag_out    = tags[MUL_LAT-1];
    assign last_res   = tag_out.valid && (tag_out.idx == IDX_W'(NUM_TAPS - 1));
    assign op_tap     = op_buf[k*TAP_W +: TAP_W];

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tag_in    = '0;
        case (state)
            IDLE:  if (in_valid) state_nxt = ISSUE;
            ISSUE: begin
                tag_in = tag_t'{valid: 1'b1, idx: k};
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: if (last_res) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    multiplier8bit8 #(.LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .rst (rst),
        .op1 (op_tap),
        .op2 (op_tap),
        .res (mul_res)
    );

    // Results land only behind a valid tag, so multiplier garbage is never stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k      <= '0;
            op_buf <= '0;
            c_out  <= '0;
            p_out  <= '0;
            for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
        end else begin
            if (accept) begin
                op_buf <= c_in;
                p_out  <= p_in;
                k      <= '0;
            end else if (state == ISSUE && !last_issue) begin
                k <= k + 1'b1;
            end
            tags[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
            if (tag_out.valid) c_out[tag_out.idx*TAP_W +: TAP_W] <= mul_res;
        end
    end

`ifdef SQ_SEQ_WINCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        win_count <= '0;
        else if (out_hs) win_count <= win_count + 16'd1;
    end
`else
    logic unused_hs;
    assign unused_hs = out_hs;
`endif
endmodule

// File: tb/tb_sq_window_sequencer.sv
// Directed self-checking bench for sq_window_sequencer with MUL_LAT = 1.
module tb_sq_window_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [71:0] c_in = '0;
    logic [71:0] p_in = '0;
    logic        in_ready, out_valid, busy;
    logic [71:0] c_out, p_out;
`ifdef SQ_SEQ_WINCNT_EN
    logic [15:0] win_count;
`endif

    int checks = 0;
    int errors = 0;

    sq_window_sequencer #(.MUL_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .p_in      (p_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .p_out     (p_out),
        .busy      (busy)
`ifdef SQ_SEQ_WINCNT_EN
        ,
        .win_count (win_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sq8(input logic [7:0] v);
        logic [15:0] t;
        t = {8'd0, v} * {8'd0, v};
        return t[7:0];
    endfunction

    // Presents one window, then waits (bounded) for out_valid; leaves time at T+lat+1ns.
    task automatic send_and_wait(input logic [71:0] c, input logic [71:0] p, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {71'd0, in_ready}, 72'd1);
        c_in = c;
        p_in = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, {71'd0, busy}, 72'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 72'(lat), 72'd10);
    endtask

    logic [7:0]  v;
    logic        rdy;
    logic [7:0]  acc_v [8];
    int          acc_t [8];
    int          acc_cnt, out_cnt, wait_cyc;
    logic [71:0] hold_c, hold_p;

    initial begin
        #1;
        check("rst_in_ready", {71'd0, in_ready}, 72'd1);
        check("rst_out_valid", {71'd0, out_valid}, 72'd0);
        check("rst_busy", {71'd0, busy}, 72'd0);
        check("rst_c_out", c_out, 72'd0);
        check("rst_p_out", p_out, 72'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        // Taps 1..9 with out_ready held high.
        out_ready = 1'b1;
        send_and_wait(72'h09_08_07_06_05_04_03_02_01, 72'hA9_A8_A7_A6_A5_A4_A3_A2_A1, "w1");
        check("w1_c_out", c_out, 72'h51_40_31_24_19_10_09_04_01);
        check("w1_p_out", p_out, 72'hA9_A8_A7_A6_A5_A4_A3_A2_A1);
        @(posedge clk);
        #1;
        check("w1_hs_out_valid", {71'd0, out_valid}, 72'd0);
        check("w1_hs_in_ready", {71'd0, in_ready}, 72'd1);

        // All 0xFF taps with backpressure for 5 cycles.
        out_ready = 1'b0;
        send_and_wait({9{8'hFF}}, 72'h12_34_56_78_9A_BC_DE_F0_12, "w2");
        check("w2_c_out", c_out, {9{8'h01}});
        check("w2_p_out", p_out, 72'h12_34_56_78_9A_BC_DE_F0_12);
        hold_c = c_out;
        hold_p = p_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {71'd0, out_valid}, 72'd1);
            check("hold_in_ready", {71'd0, in_ready}, 72'd0);
            check("hold_c_out", c_out, {9{8'h01}});
            check("hold_p_out", p_out, 72'h12_34_56_78_9A_BC_DE_F0_12);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rel_out_valid", {71'd0, out_valid}, 72'd0);
        check("rel_in_ready", {71'd0, in_ready}, 72'd1);
        check("idle_keeps_c_out", c_out, {9{8'h01}});

        // in_valid held high with data changing every cycle.
        acc_cnt = 0;
        out_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            v = 8'(16 + 3 * cyc);
            c_in = {9{v}};
            p_in = {9{~v}};
            in_valid = 1'b1;
            rdy = in_ready;
            @(posedge clk);
            if (rdy && acc_cnt < 8) begin
                acc_v[acc_cnt] = v;
                acc_t[acc_cnt] = cyc;
                acc_cnt++;
            end
            #1;
            if (out_valid && out_cnt < acc_cnt) begin
                check("stream_c_out", c_out, {9{sq8(acc_v[out_cnt])}});
                check("stream_p_out", p_out, {9{~acc_v[out_cnt]}});
                out_cnt++;
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", 72'(acc_cnt), 72'd4);
        check("stream_outputs", 72'(out_cnt), 72'd3);
        check("stream_first_t", 72'(acc_t[0]), 72'd0);
        check("stream_gap1", 72'(acc_t[1] - acc_t[0]), 72'd12);
        check("stream_gap2", 72'(acc_t[2] - acc_t[1]), 72'd12);
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 40) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        check("stream_drain_idle", {71'd0, in_ready}, 72'd1);

        // Reset while issuing tap k=4.
        @(negedge clk);
        c_in = 72'h19_18_17_16_15_14_13_12_11;
        p_in = 72'hC9_C8_C7_C6_C5_C4_C3_C2_C1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", {71'd0, busy}, 72'd1);
        rst = 1'b0;
        #1;
        check("abort_in_ready", {71'd0, in_ready}, 72'd1);
        check("abort_out_valid", {71'd0, out_valid}, 72'd0);
        check("abort_busy_rst", {71'd0, busy}, 72'd0);
        check("abort_c_out", c_out, 72'd0);
        check("abort_p_out", p_out, 72'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_abort_c_out", c_out, 72'd0);
        check("post_abort_out_valid", {71'd0, out_valid}, 72'd0);
        send_and_wait(72'h0A_09_08_07_06_05_04_03_02, 72'hB9_B8_B7_B6_B5_B4_B3_B2_B1, "w3");
        check("w3_c_out", c_out, 72'h64_51_40_31_24_19_10_09_04);
        check("w3_p_out", p_out, 72'hB9_B8_B7_B6_B5_B4_B3_B2_B1);
        @(posedge clk);
        #1;

`ifdef SQ_SEQ_WINCNT_EN
        @(negedge clk);
        force dut.win_count = 16'hFFFE;
        #1;
        release dut.win_count;
        send_and_wait({9{8'h03}}, '0, "cnt1");
        @(posedge clk);
        #1;
        check("win_count_1", 72'(win_count), 72'h0FFFF);
        send_and_wait({9{8'h04}}, '0, "cnt2");
        @(posedge clk);
        #1;
        check("win_count_2", 72'(win_count), 72'h00000);
        send_and_wait({9{8'h05}}, '0, "cnt3");
        @(posedge clk);
        #1;
        check("win_count_3", 72'(win_count), 72'h00001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sq_window_sequencer.md
# sq_window_sequencer

Time-multiplexed controller that squares all nine 8-bit taps of a 3x3 window through one shared `multiplier8bit8` instance. It replaces nine parallel squarers where area matters. It accepts one window at a time over a valid/ready handshake, carrying the nine `p` bytes alongside. It issues one tap per cycle to the multiplier, collects the nine results, then presents the squared taps and the delayed `p` bytes together.

## Interface
- `MUL_LAT`, default 1: register latency of `multiplier8bit8`, in cycles from operand to `res`; legal range 1–4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a window is presented on `c_in` and `p_in`.
- `in_ready`  out  1  the block can accept a window; high only in IDLE.
- `c_in`  in  72  taps c1..c9; c1 occupies bits [7:0], c9 occupies bits [71:64].
- `p_in`  in  72  side-band bytes p1..p9, same packing; not processed.
- `out_valid`  out  1  `c_out` and `p_out` hold a completed window.
- `out_ready`  in  1  downstream accepts the window.
- `c_out`  out  72  squared taps; each byte equals `res` from `multiplier8bit8` for that tap (low byte of the product).
- `p_out`  out  72  `p_in` as captured at acceptance.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: wait for `in_valid`.
  - ISSUE: send taps to the multiplier.
  - DRAIN: wait for the remaining results.
  - DONE: hold the output until downstream accepts it.
- IDLE → ISSUE on an edge with `in_valid` && `in_ready`. On that edge, capture `c_in` into the operand buffer and `p_in` into `p_out`, and clear tap index `k` to 0.
- ISSUE: drive `op1` = `op2` = tap `k`, with `k` = 0..8, one tap per cycle. Push tag {valid=1, idx=k} into a tag shift register `MUL_LAT` deep.
- After tap 8 is issued, move to DRAIN.
- DRAIN: push tags with valid=0. When a tag leaving the shift register is valid, write `res` into `c_out` slot idx.
- Results are captured only on valid tags. Garbage or post-reset values from the multiplier are never stored.
- DRAIN → DONE on the edge that captures idx 8. `out_valid` rises in DONE.
- DONE: hold `c_out`, `p_out` and `out_valid` stable while `out_ready` is low.
- DONE → IDLE on `out_valid` && `out_ready`. `out_valid` falls on that edge; `in_ready` rises on that edge.
- A new window is accepted no earlier than the cycle after the output handshake. No window overlap and no back-to-back acceptance.
- `in_valid` while not in IDLE is ignored, and the input is not captured.
- `c_out` and `p_out` keep their last values in IDLE. They are not cleared at handshake.

## Timing
- Reset values, asynchronous and active-low, apply to all state:
  - state = IDLE, `k` = 0, tags = 0.
  - `c_out` = 0, `p_out` = 0.
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0.
- The multiplier instance receives the same `clk` and `rst`.
- Latency: with the acceptance edge at T, `out_valid` is high from edge T+9+`MUL_LAT`. With `MUL_LAT`=1 that is T+10.
- Throughput: at best one window per 11+`MUL_LAT` cycles, i.e. 12 cycles with `MUL_LAT`=1 when `out_ready` is held high.
- Reset mid-operation, in any state, aborts the window. It causes no output handshake and no partial `c_out` update after reset deasserts.
- In-flight multiplier results are discarded because the tags are cleared.

## Configuration
- `SQ_SEQ_WINCNT_EN` defined: adds output `win_count` (out, 16 bits).
  - Reset value 0.
  - Increments on each output handshake; 0xFFFF wraps to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `sq_seq_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - `NUM_TAPS` = 9, `TAP_W` = 8, `IDX_W` = 4;
  - tag struct {valid, idx}.
- One sub-module instance: the existing `multiplier8bit8`. No new sub-module; the tag shift register is inline.

## Test plan
- Taps c1..c9 = 1..9, p = 0xA1..0xA9, `out_ready` held high. Expected `c_out` bytes 1, 4, 9, 16, 25, 36, 49, 64, 81; `p_out` = 0xA1..0xA9; `out_valid` at T+10.
- All taps 0xFF, which checks truncation. Expected every `c_out` byte 0x01, i.e. the low byte of 65025.
- Hold `out_ready` low for 5 cycles in DONE. Expected `out_valid`, `c_out` and `p_out` stable and `in_ready` = 0. Release `out_ready`: handshake, then `in_ready` = 1 on the next cycle.
- Hold `in_valid` high continuously with changing data. Expected only windows present on IDLE acceptance edges to be captured; windows 12 cycles apart.
- Assert `rst` low during ISSUE at `k`=4. Expected all outputs at reset values immediately. After release, a new window of taps 2..10 produces squares 4..100 with no residue from the aborted window.
- With `SQ_SEQ_WINCNT_EN` defined, start from preloaded count 0xFFFE and run 3 windows. Expected `win_count` = 0xFFFF, then 0x0000, then 0x0001.
